// File: rtl/gc_mss_if.sv
// APB bus between the MSS master port and the fabric slave.
interface gc_mss_if;
  logic        MSSPSEL;
  logic        MSSPENABLE;
  logic        MSSPWRITE;
  logic [19:0] MSSPADDR;
  logic [31:0] MSSPWDATA;
  logic        MSSPREADY;
  logic        MSSPSLVERR;
  logic [31:0] MSSPRDATA;

  modport master (
    output MSSPSEL, MSSPENABLE, MSSPWRITE, MSSPADDR, MSSPWDATA,
    input  MSSPREADY, MSSPSLVERR, MSSPRDATA
  );

  modport slave (
    input  MSSPSEL, MSSPENABLE, MSSPWRITE, MSSPADDR, MSSPWDATA,
    output MSSPREADY, MSSPSLVERR, MSSPRDATA
  );
endinterface

// File: rtl/gc_mss.sv
// MSS model: UART_0 byte commands become APB transfers with a status/data
// reply, UART_1 echoes bytes, and the fabric clock/reset are provided.

// 8N1 receiver; start bit re-checked at half bit, data sampled mid-bit.
module gc_mss_uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       vld,
  output logic [7:0] dat
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_e;

  rx_st_e        st;
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic [2:0]    bidx;
  logic [7:0]    sh;
  logic          s;

  assign s = sync[1];

  // Two-flop synchronizer, idles high so reset never looks like a start bit.
  always_ff @(posedge clk)
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rxd};

  // Bit-timing FSM; a byte is only delivered when its stop bit reads 1.
  always_ff @(posedge clk)
    if (rst) begin
      st   <= R_IDLE;
      cnt  <= '0;
      bidx <= '0;
      sh   <= '0;
      vld  <= 1'b0;
      dat  <= '0;
    end else begin
      vld <= 1'b0;
      case (st)
        R_IDLE:
          if (!s) begin
            st  <= R_START;
            cnt <= '0;
          end
        R_START:
          if (cnt == CW'(HALF - 1)) begin
            cnt  <= '0;
            bidx <= '0;
            st   <= s ? R_IDLE : R_DATA;
          end else cnt <= cnt + CW'(1);
        R_DATA:
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt  <= '0;
            sh   <= {s, sh[7:1]};
            bidx <= bidx + 3'd1;
            if (bidx == 3'd7) st <= R_STOP;
          end else cnt <= cnt + CW'(1);
        R_STOP:
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt <= '0;
            st  <= R_IDLE;
            if (s) begin
              vld <= 1'b1;
              dat <= sh;
            end
          end else cnt <= cnt + CW'(1);
        default: st <= R_IDLE;
      endcase
    end
endmodule

// 8N1 transmitter; accepts a byte when vld is high and busy is low.
module gc_mss_uart_tx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vld,
  input  logic [7:0] dat,
  output logic       busy,
  output logic       txd
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;
  logic [8:0]    sh;
  logic [3:0]    nb;

  // Start bit goes out on accept; sh holds data plus stop, shifted LSB first.
  always_ff @(posedge clk)
    if (rst) begin
      busy <= 1'b0;
      txd  <= 1'b1;
      cnt  <= '0;
      sh   <= '1;
      nb   <= '0;
    end else if (!busy) begin
      if (vld) begin
        busy <= 1'b1;
        txd  <= 1'b0;
        sh   <= {1'b1, dat};
        cnt  <= '0;
        nb   <= '0;
      end
    end else if (cnt == CW'(CLKS_PER_BIT - 1)) begin
      cnt <= '0;
      if (nb == 4'd9) begin
        busy <= 1'b0;
        txd  <= 1'b1;
      end else begin
        txd <= sh[0];
        sh  <= {1'b1, sh[8:1]};
        nb  <= nb + 4'd1;
      end
    end else cnt <= cnt + CW'(1);
endmodule

module gc_mss #(
  parameter int CLKS_PER_BIT = 87,
  parameter int APB_TIMEOUT  = 255,
  parameter int RST_DELAY    = 4
) (
  input  logic     SYSCLK,
  input  logic     MSS_RESET,
  input  logic     UART_0_RXD,
  input  logic     UART_1_RXD,
  output logic     FAB_CLK,
  output logic     M2F_RESET_N,
  output logic     UART_0_TXD,
  output logic     UART_1_TXD,
  gc_mss_if.master apb
);
  localparam int NUM_CH = 2;
  localparam int TW     = $clog2(APB_TIMEOUT + 1);
  localparam int RW     = $clog2(RST_DELAY + 2);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ST_K  = 8'h4B;
  localparam logic [7:0] ST_E  = 8'h45;
  localparam logic [7:0] ST_T  = 8'h54;

  typedef enum logic [2:0] {
    P_IDLE, P_ADDR, P_DATA, P_SETUP, P_ACCESS, P_RESP
  } p_st_e;

  logic [NUM_CH-1:0]      rxd, txd, rx_vld, tx_vld, tx_busy;
  logic [NUM_CH-1:0][7:0] rx_dat, tx_dat;

  assign FAB_CLK    = SYSCLK;
  assign rxd        = {UART_1_RXD, UART_0_RXD};
  assign UART_0_TXD = txd[0];
  assign UART_1_TXD = txd[1];

  // Channel 0 = command link, channel 1 = echo link.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gc_mss_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk(SYSCLK), .rst(MSS_RESET), .rxd(rxd[c]),
      .vld(rx_vld[c]), .dat(rx_dat[c])
    );
    gc_mss_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk(SYSCLK), .rst(MSS_RESET), .vld(tx_vld[c]), .dat(tx_dat[c]),
      .busy(tx_busy[c]), .txd(txd[c])
    );
  end

  // ---------------- fabric reset ----------------
  logic [RW-1:0] rcnt;
  logic          m2f_q;

  assign M2F_RESET_N = m2f_q;

  // Count non-reset edges; release the fabric once RST_DELAY have passed.
  always_ff @(posedge SYSCLK)
    if (MSS_RESET) begin
      rcnt  <= '0;
      m2f_q <= 1'b0;
    end else if (rcnt == RW'(RST_DELAY)) m2f_q <= 1'b1;
    else rcnt <= rcnt + RW'(1);

  // ---------------- echo channel ----------------
  logic       hold_vld;
  logic [7:0] hold_dat;

  assign tx_vld[1] = hold_vld;
  assign tx_dat[1] = hold_dat;

  // Single-byte holding buffer; arrivals while it is full are dropped.
  always_ff @(posedge SYSCLK)
    if (MSS_RESET) begin
      hold_vld <= 1'b0;
      hold_dat <= '0;
    end else if (hold_vld && !tx_busy[1]) hold_vld <= 1'b0;
    else if (rx_vld[1] && !hold_vld) begin
      hold_vld <= 1'b1;
      hold_dat <= rx_dat[1];
    end

  // ---------------- command parser / APB master ----------------
  p_st_e         pst;
  logic          is_wr;
  logic [1:0]    bcnt;
  logic [23:0]   addr_sh;
  logic [31:0]   wdata_sh;
  logic [TW-1:0] to_cnt;
  logic [39:0]   resp;
  logic [2:0]    resp_left;
  logic          p_tx_vld;
  logic [7:0]    p_tx_dat;
  logic          psel_q, pen_q, pwr_q;
  logic [19:0]   paddr_q;
  logic [31:0]   pwdata_q;

  assign tx_vld[0]      = p_tx_vld;
  assign tx_dat[0]      = p_tx_dat;
  assign apb.MSSPSEL    = psel_q;
  assign apb.MSSPENABLE = pen_q;
  assign apb.MSSPWRITE  = pwr_q;
  assign apb.MSSPADDR   = paddr_q;
  assign apb.MSSPWDATA  = pwdata_q;

  // Collect command bytes, run one APB transfer, then stream the reply.
  // Bytes arriving outside IDLE/ADDR/DATA fall through and are lost.
  always_ff @(posedge SYSCLK)
    if (MSS_RESET) begin
      pst       <= P_IDLE;
      is_wr     <= 1'b0;
      bcnt      <= '0;
      addr_sh   <= '0;
      wdata_sh  <= '0;
      to_cnt    <= '0;
      resp      <= '0;
      resp_left <= '0;
      p_tx_vld  <= 1'b0;
      p_tx_dat  <= '0;
      psel_q    <= 1'b0;
      pen_q     <= 1'b0;
      pwr_q     <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      p_tx_vld <= 1'b0;
      case (pst)
        P_IDLE:
          if (rx_vld[0]) begin
            bcnt <= '0;
            if (rx_dat[0] == CMD_W) begin
              is_wr <= 1'b1;
              pst   <= P_ADDR;
            end else if (rx_dat[0] == CMD_R) begin
              is_wr <= 1'b0;
              pst   <= P_ADDR;
            end
          end
        P_ADDR:
          if (rx_vld[0]) begin
            addr_sh <= {addr_sh[15:0], rx_dat[0]};
            if (bcnt == 2'd2) begin
              bcnt <= '0;
              if (is_wr) pst <= P_DATA;
              else begin
                // Read: launch setup straight from the last address byte.
                pst     <= P_SETUP;
                psel_q  <= 1'b1;
                pwr_q   <= 1'b0;
                paddr_q <= {addr_sh[11:0], rx_dat[0]};
              end
            end else bcnt <= bcnt + 2'd1;
          end
        P_DATA:
          if (rx_vld[0]) begin
            wdata_sh <= {wdata_sh[23:0], rx_dat[0]};
            if (bcnt == 2'd3) begin
              bcnt     <= '0;
              pst      <= P_SETUP;
              psel_q   <= 1'b1;
              pwr_q    <= 1'b1;
              paddr_q  <= addr_sh[19:0];
              pwdata_q <= {wdata_sh[23:0], rx_dat[0]};
            end else bcnt <= bcnt + 2'd1;
          end
        P_SETUP: begin
          pen_q  <= 1'b1;
          to_cnt <= '0;
          pst    <= P_ACCESS;
        end
        P_ACCESS:
          if (apb.MSSPREADY) begin
            psel_q    <= 1'b0;
            pen_q     <= 1'b0;
            resp      <= {apb.MSSPSLVERR ? ST_E : ST_K, apb.MSSPRDATA};
            resp_left <= is_wr ? 3'd1 : 3'd5;
            pst       <= P_RESP;
          end else if (to_cnt == TW'(APB_TIMEOUT - 1)) begin
            psel_q    <= 1'b0;
            pen_q     <= 1'b0;
            resp      <= {ST_T, 32'h0};
            resp_left <= is_wr ? 3'd1 : 3'd5;
            pst       <= P_RESP;
          end else to_cnt <= to_cnt + TW'(1);
        P_RESP:
          // One-cycle offer per byte; finish once the last stop bit is out.
          if (!p_tx_vld && !tx_busy[0]) begin
            if (resp_left != 3'd0) begin
              p_tx_vld  <= 1'b1;
              p_tx_dat  <= resp[39:32];
              resp      <= {resp[31:0], 8'h00};
              resp_left <= resp_left - 3'd1;
            end else pst <= P_IDLE;
          end
        default: pst <= P_IDLE;
      endcase
    end
endmodule

// File: tb/tb_gc_mss.sv
// Bench for gc_mss: UART command frames driven bit by bit, an APB slave
// emulated in-line, replies decoded from the TX line and compared with
// values built from the command/status rules.
module tb_gc_mss;
  localparam int CPB = 8;
  localparam int TO  = 20;
  localparam int RD  = 4;

  logic SYSCLK = 1'b0;
  logic MSS_RESET = 1'b1;
  logic UART_0_RXD = 1'b1;
  logic UART_1_RXD = 1'b1;
  logic FAB_CLK, M2F_RESET_N, UART_0_TXD, UART_1_TXD;

  int checks = 0;
  int failures = 0;

  gc_mss_if apb();

  gc_mss #(.CLKS_PER_BIT(CPB), .APB_TIMEOUT(TO), .RST_DELAY(RD)) dut (
    .SYSCLK(SYSCLK), .MSS_RESET(MSS_RESET),
    .UART_0_RXD(UART_0_RXD), .UART_1_RXD(UART_1_RXD),
    .FAB_CLK(FAB_CLK), .M2F_RESET_N(M2F_RESET_N),
    .UART_0_TXD(UART_0_TXD), .UART_1_TXD(UART_1_TXD),
    .apb(apb)
  );

  always #5 SYSCLK = ~SYSCLK;

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic drive(input int ch, input logic v);
    if (ch == 0) UART_0_RXD = v;
    else         UART_1_RXD = v;
  endtask

  function automatic logic txd_of(input int ch);
    return (ch == 0) ? UART_0_TXD : UART_1_TXD;
  endfunction

  task automatic uart_send(input int ch, input logic [7:0] b, input logic stop);
    drive(ch, 1'b0);
    repeat (CPB) @(negedge SYSCLK);
    for (int i = 0; i < 8; i++) begin
      drive(ch, b[i]);
      repeat (CPB) @(negedge SYSCLK);
    end
    drive(ch, stop);
    repeat (CPB) @(negedge SYSCLK);
    drive(ch, 1'b1);
    if (!stop) repeat (2 * CPB) @(negedge SYSCLK);
  endtask

  task automatic uart_recv(input int ch, output logic [7:0] b, output bit ok);
    bit found = 0;
    ok = 0;
    b = '0;
    for (int n = 0; n < 3000 && !found; n++) begin
      @(negedge SYSCLK);
      if (txd_of(ch) == 1'b0) found = 1;
    end
    if (!found) return;
    repeat (CPB / 2) @(negedge SYSCLK);
    if (txd_of(ch) != 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge SYSCLK);
      b[i] = txd_of(ch);
    end
    repeat (CPB) @(negedge SYSCLK);
    ok = (txd_of(ch) == 1'b1);
  endtask

  // Plays the APB slave for one transfer and reports what it observed.
  task automatic apb_serve(input int waits, input bit err, input bit never,
                           input logic [31:0] rd, output bit seen, output bit setup_ok,
                           output int en_cyc, output bit stable, output bit idle_ok,
                           output logic [19:0] a, output bit w, output logic [31:0] wd);
    seen = 0; setup_ok = 0; en_cyc = 0; stable = 1; idle_ok = 0;
    a = '0; w = 0; wd = '0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge SYSCLK);
      if (apb.MSSPSEL === 1'b1) seen = 1;
    end
    if (!seen) return;
    setup_ok = (apb.MSSPENABLE === 1'b0);
    a = apb.MSSPADDR; w = apb.MSSPWRITE; wd = apb.MSSPWDATA;
    apb.MSSPREADY = 1'b0;
    for (int n = 0; n < TO + 10; n++) begin
      @(negedge SYSCLK);
      if (apb.MSSPENABLE !== 1'b1) break;
      en_cyc++;
      if (apb.MSSPSEL !== 1'b1 || apb.MSSPADDR !== a || apb.MSSPWRITE !== w ||
          (w && apb.MSSPWDATA !== wd)) stable = 0;
      apb.MSSPREADY  = !never && (en_cyc > waits);
      apb.MSSPSLVERR = err;
      apb.MSSPRDATA  = rd;
    end
    idle_ok = (apb.MSSPSEL === 1'b0) && (apb.MSSPENABLE === 1'b0);
    apb.MSSPREADY = 1'b0; apb.MSSPSLVERR = 1'b0; apb.MSSPRDATA = '0;
  endtask

  // Sends one command and checks the transfer and the reply against the rules.
  task automatic run_cmd(input string tag, input bit wr, input logic [23:0] a24,
                         input logic [31:0] wdat, input int waits, input bit err,
                         input bit never, input logic [31:0] rd);
    logic [7:0] cmd[$];
    logic [7:0] exp_rsp[$];
    bit seen, setup_ok, stable, idle_ok, w, ok;
    int en_cyc;
    logic [19:0] a;
    logic [31:0] wdo;
    logic [7:0] b;
    cmd.push_back(wr ? 8'h57 : 8'h52);
    for (int i = 2; i >= 0; i--) cmd.push_back(a24[8*i +: 8]);
    if (wr) for (int i = 3; i >= 0; i--) cmd.push_back(wdat[8*i +: 8]);
    exp_rsp.push_back(never ? 8'h54 : (err ? 8'h45 : 8'h4B));
    if (!wr) for (int i = 3; i >= 0; i--) exp_rsp.push_back(never ? 8'h00 : rd[8*i +: 8]);
    for (int i = 0; i < cmd.size() - 1; i++) uart_send(0, cmd[i], 1'b1);
    fork
      uart_send(0, cmd[cmd.size() - 1], 1'b1);
      begin
        apb_serve(waits, err, never, rd, seen, setup_ok, en_cyc, stable, idle_ok, a, w, wdo);
        check({tag, "_psel_seen"}, seen, 1);
        check({tag, "_setup"}, setup_ok, 1);
        check({tag, "_enable_cycles"}, en_cyc, never ? TO : waits + 1);
        check({tag, "_stable"}, stable, 1);
        check({tag, "_idle_after"}, idle_ok, 1);
        check({tag, "_addr"}, a, a24 % (1 << 20));
        check({tag, "_write"}, w, wr);
        if (wr) check({tag, "_wdata"}, wdo, wdat);
        for (int i = 0; i < exp_rsp.size(); i++) begin
          uart_recv(0, b, ok);
          check($sformatf("%s_rsp%0d_frame", tag, i), ok, 1);
          check($sformatf("%s_rsp%0d", tag, i), b, exp_rsp[i]);
        end
      end
    join
  endtask

  initial begin
    logic [7:0] b, v;
    bit ok, quiet, seen, setup_ok, stable, idle_ok, w;
    int en_cyc;
    logic [19:0] a;
    logic [31:0] wdo;
    logic [7:0] wcmd[8];

    apb.MSSPREADY = 1'b0; apb.MSSPSLVERR = 1'b0; apb.MSSPRDATA = '0;

    // reset values and fabric reset release timing
    repeat (10) @(negedge SYSCLK);
    check("rst_m2f", M2F_RESET_N, 0);
    check("rst_psel", apb.MSSPSEL, 0);
    check("rst_penable", apb.MSSPENABLE, 0);
    check("rst_pwrite", apb.MSSPWRITE, 0);
    check("rst_paddr", apb.MSSPADDR, 0);
    check("rst_pwdata", apb.MSSPWDATA, 0);
    check("rst_txd0", UART_0_TXD, 1);
    check("rst_txd1", UART_1_TXD, 1);
    MSS_RESET = 1'b0;
    for (int k = 0; k <= RD; k++) begin
      @(negedge SYSCLK);
      check($sformatf("m2f_edge%0d", k), M2F_RESET_N, (k == RD));
    end
    check("fabclk_low", FAB_CLK, 0);
    @(posedge SYSCLK); #1;
    check("fabclk_high", FAB_CLK, 1);
    @(negedge SYSCLK);

    // directed write, waited read, slave error, timeout
    run_cmd("wr_fixed", 1, 24'h000123, 32'hDEADBEEF, 0, 0, 0, 32'h0);
    run_cmd("rd_wait", 0, 24'h0FFFFC, 32'h0, 3, 0, 0, 32'h12345678);
    run_cmd("rd_err", 0, 24'($urandom), 32'h0, 0, 1, 0, $urandom);
    run_cmd("rd_to", 0, 24'($urandom), 32'h0, 0, 0, 1, $urandom);

    // junk byte, glitch, bad-stop 'R', then a valid read
    uart_send(0, 8'h33, 1'b1);
    UART_0_RXD = 1'b0;
    repeat (2) @(negedge SYSCLK);
    UART_0_RXD = 1'b1;
    repeat (2 * CPB) @(negedge SYSCLK);
    uart_send(0, 8'h52, 1'b0);
    quiet = 1;
    for (int n = 0; n < 30 * CPB; n++) begin
      @(negedge SYSCLK);
      if (UART_0_TXD !== 1'b1 || apb.MSSPSEL !== 1'b0) quiet = 0;
    end
    check("junk_quiet", quiet, 1);
    run_cmd("rd_after_junk", 0, 24'($urandom), 32'h0, 1, 0, 0, $urandom);

    // echo channel
    for (int i = 0; i < 2; i++) begin
      v = (i == 0) ? 8'hA5 : 8'($urandom);
      fork
        uart_send(1, v, 1'b1);
        uart_recv(1, b, ok);
      join
      check($sformatf("echo%0d_frame", i), ok, 1);
      check($sformatf("echo%0d", i), b, v);
    end

    // randomized commands
    for (int i = 0; i < 6; i++)
      run_cmd($sformatf("rnd%0d", i), 1'($urandom), 24'($urandom), $urandom,
              int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 0, $urandom);

    // reset during APB access
    uart_send(0, 8'h52, 1'b1);
    for (int i = 0; i < 3; i++) uart_send(0, 8'($urandom), 1'b1);
    seen = 0;
    for (int n = 0; n < 2 * TO && !seen; n++) begin
      if (apb.MSSPENABLE === 1'b1) seen = 1;
      else @(negedge SYSCLK);
    end
    check("rstacc_enable_seen", seen, 1);
    repeat (3) @(negedge SYSCLK);
    MSS_RESET = 1'b1;
    @(negedge SYSCLK);
    check("rstacc_psel", apb.MSSPSEL, 0);
    check("rstacc_penable", apb.MSSPENABLE, 0);
    check("rstacc_txd0", UART_0_TXD, 1);
    check("rstacc_m2f", M2F_RESET_N, 0);
    MSS_RESET = 1'b0;
    repeat (RD + 2) @(negedge SYSCLK);
    check("rstacc_m2f_back", M2F_RESET_N, 1);

    // reset during a response byte
    wcmd = '{8'h57, 8'h00, 8'h00, 8'h44, 8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 7; i++) uart_send(0, wcmd[i], 1'b1);
    fork
      uart_send(0, wcmd[7], 1'b1);
      begin
        apb_serve(0, 0, 0, 32'h0, seen, setup_ok, en_cyc, stable, idle_ok, a, w, wdo);
        check("rsttx_psel_seen", seen, 1);
        seen = 0;
        for (int n = 0; n < 200 && !seen; n++) begin
          @(negedge SYSCLK);
          if (UART_0_TXD === 1'b0) seen = 1;
        end
        check("rsttx_start_seen", seen, 1);
        repeat (3 * CPB) @(negedge SYSCLK);
        check("rsttx_bit2_low", UART_0_TXD, 0);
        MSS_RESET = 1'b1;
        @(negedge SYSCLK);
        check("rsttx_txd0", UART_0_TXD, 1);
        check("rsttx_m2f", M2F_RESET_N, 0);
        check("rsttx_psel", apb.MSSPSEL, 0);
        MSS_RESET = 1'b0;
      end
    join
    repeat (RD + 2) @(negedge SYSCLK);
    quiet = 1;
    for (int n = 0; n < 12 * CPB; n++) begin
      @(negedge SYSCLK);
      if (UART_0_TXD !== 1'b1) quiet = 0;
    end
    check("rsttx_no_resume", quiet, 1);
    run_cmd("post_rst", 0, 24'($urandom), 32'h0, 2, 0, 0, $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
